// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scanline scheduler and its attribute table.
package sprite_pkg;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int ID_W     = 6;
  localparam int COORD_W  = 10;

  typedef logic [23:0] pixel_t;
  typedef pixel_t [SPRITE_W-1:0] sprite_row_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // Row of the sprite that lands on the requested scanline, modulo the 10-bit coordinate space.
  function automatic logic [COORD_W-1:0] row_offset(input logic [COORD_W-1:0] line,
                                                    input logic [COORD_W-1:0] y);
    return line - y;
  endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: synchronous write, combinational read, cleared on reset.
import sprite_pkg::*;

module sprite_attr_table #(
  parameter int NSPRITES = 16,
  localparam int AW = $clog2(NSPRITES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  sprite_attr_t wdata,
  input  logic [AW-1:0] raddr,
  output sprite_attr_t rdata
);

  sprite_attr_t mem [NSPRITES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSPRITES; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write in the same cycle as a read of that entry returns the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table in hblank and copies hit rows into line-buffer slots.
import sprite_pkg::*;

module sprite_line_scheduler #(
  parameter int NSPRITES = 16,
  parameter int SLOTS    = 8,
  localparam int AW      = $clog2(NSPRITES),
  localparam int SW      = $clog2(SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 attr_we,
  input  logic [AW-1:0]        attr_addr,
  input  logic [25:0]          attr_data,
  input  logic                 start,
  input  logic [COORD_W-1:0]   next_line,
  output logic [ID_W-1:0]      rom_sprite,
  output logic [COORD_W-1:0]   rom_line,
  input  sprite_row_t          rom_pattern,
  output logic                 slot_we,
  output logic [SW-1:0]        slot_idx,
  output logic [COORD_W-1:0]   slot_x,
  output sprite_row_t          slot_pattern,
  output logic [SW:0]          slot_count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [2:0]           dbg_state
);

  // start is a single-cycle request honoured only in IDLE (no ready); slot_we and
  // done are single-cycle strobes with no backpressure, the consumer must accept them.

  sched_state_t         state, state_nx;
  logic [AW-1:0]        idx;
  logic [COORD_W-1:0]   line_q;
  sprite_attr_t         entry;
  logic [COORD_W-1:0]   diff;
  logic                 hit, slots_full, last_entry;

  sprite_attr_table #(.NSPRITES(NSPRITES)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (attr_we),
    .waddr (attr_addr),
    .wdata (sprite_attr_t'(attr_data)),
    .raddr (idx),
    .rdata (entry)
  );

  assign diff       = row_offset(line_q, entry.y);
  assign hit        = (entry.id != '0) && (diff < COORD_W'(SPRITE_H));
  assign slots_full = (slot_count == (SW+1)'(SLOTS));
  assign last_entry = (idx == AW'(NSPRITES-1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (hit && !slots_full) state_nx = ST_FETCH;
        else if (last_entry)    state_nx = ST_DONE;
      end
      ST_FETCH: state_nx = ST_WRITE;
      ST_WRITE: state_nx = last_entry ? ST_DONE : ST_SCAN;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Scan index, slot counter and the registered ROM address / slot x.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      line_q     <= '0;
      slot_count <= '0;
      overflow   <= 1'b0;
      rom_sprite <= '0;
      rom_line   <= '0;
      slot_x     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            line_q     <= next_line;
            idx        <= '0;
            slot_count <= '0;
            overflow   <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (hit && !slots_full) begin
            rom_sprite <= entry.id;
            rom_line   <= diff;
            slot_x     <= entry.x;
          end else begin
            if (hit) overflow <= 1'b1;
            idx <= idx + AW'(1);
          end
        end
        ST_WRITE: begin
          slot_count <= slot_count + (SW+1)'(1);
          idx        <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked by reset so nothing leaves the block once reset is seen.
  always_comb begin
    slot_we      = (state == ST_WRITE) && !reset;
    done         = (state == ST_DONE) && !reset;
    busy         = (state != ST_IDLE);
    slot_idx     = slot_we ? slot_count[SW-1:0] : '0;
    slot_pattern = slot_we ? rom_pattern : '0;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomised and directed checks of sprite_line_scheduler against a table-walk reference model.
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  localparam int NSPRITES = 16;
  localparam int SLOTS    = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               attr_we = 1'b0;
  logic [3:0]         attr_addr = '0;
  logic [25:0]        attr_data = '0;
  logic               start = 1'b0;
  logic [9:0]         next_line = '0;
  logic [5:0]         rom_sprite;
  logic [9:0]         rom_line;
  sprite_row_t        rom_pattern = '0;
  logic               slot_we;
  logic [2:0]         slot_idx;
  logic [9:0]         slot_x;
  sprite_row_t        slot_pattern;
  logic [3:0]         slot_count;
  logic               busy, done, overflow;
  logic [2:0]         dbg_state;

  int total = 0;
  int bad   = 0;

  logic [5:0] m_id [NSPRITES];
  logic [9:0] m_x  [NSPRITES];
  logic [9:0] m_y  [NSPRITES];

  typedef struct packed {
    logic [2:0] slot;
    logic [9:0] x;
    logic [5:0] id;
    logic [9:0] row;
  } wr_t;
  logic [28:0] exp_q[$];

  sprite_line_scheduler #(.NSPRITES(NSPRITES), .SLOTS(SLOTS)) dut (
    .clk(clk), .reset(reset), .attr_we(attr_we), .attr_addr(attr_addr),
    .attr_data(attr_data), .start(start), .next_line(next_line),
    .rom_sprite(rom_sprite), .rom_line(rom_line), .rom_pattern(rom_pattern),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_x(slot_x),
    .slot_pattern(slot_pattern), .slot_count(slot_count), .busy(busy),
    .done(done), .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic sprite_row_t rom_row(input logic [5:0] id, input logic [9:0] row);
    sprite_row_t r;
    for (int p = 0; p < SPRITE_W; p++) r[p] = {id, row[4:0], 5'(p), 8'hA5};
    return r;
  endfunction

  // Registered ROM: pattern appears one cycle after the address.
  always @(posedge clk) rom_pattern <= rom_row(rom_sprite, rom_line);

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NSPRITES; i++) begin
      m_id[i] = '0; m_x[i] = '0; m_y[i] = '0;
    end
  endtask

  task automatic write_attr(input int a, input logic [5:0] id, input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    attr_we = 1'b1; attr_addr = 4'(a); attr_data = {id, x, y};
    @(posedge clk); #1;
    attr_we = 1'b0;
    m_id[a] = id; m_x[a] = x; m_y[a] = y;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NSPRITES; i++) write_attr(i, 6'd0, 10'd0, 10'd0);
  endtask

  // Walk the table in index order; first SLOTS hits become writes, the rest flag overflow.
  task automatic run_scan(input logic [9:0] line, input bit poke_start);
    int hits, nwr, exp_cycles, got;
    logic [9:0] d;
    wr_t e;
    exp_q.delete();
    hits = 0;
    for (int i = 0; i < NSPRITES; i++) begin
      d = line - m_y[i];
      if (m_id[i] != 0 && d < 10'd32) begin
        if (exp_q.size() < SLOTS) exp_q.push_back({3'(exp_q.size()), m_x[i], m_id[i], d});
        hits++;
      end
    end
    nwr = exp_q.size();
    exp_cycles = NSPRITES + 2 * nwr + 1;
    got = 0;
    @(negedge clk);
    start = 1'b1; next_line = line;
    @(posedge clk); #1;
    start = 1'b0; next_line = 10'($urandom);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      chk("busy_during_scan", busy, 1'b1);
      if (slot_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          e = wr_t'(exp_q.pop_front());
          chk("slot_idx", slot_idx, e.slot);
          chk("slot_x", slot_x, e.x);
          chk("rom_sprite", rom_sprite, e.id);
          chk("rom_line", rom_line, e.row);
          chk("slot_pattern", slot_pattern, rom_row(e.id, e.row));
        end
      end
      if (done) begin got = k; break; end
      start = (poke_start && k == 5);
    end
    start = 1'b0;
    chk("done_cycle", got, exp_cycles);
    chk("missing_writes", exp_q.size(), 0);
    chk("slot_count", slot_count, nwr);
    chk("overflow", overflow, hits > SLOTS);
    @(negedge clk);
    chk("idle_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    chk("slot_count_hold", slot_count, nwr);
  endtask

  initial begin
    logic [9:0] base;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_slot_we", slot_we, 1'b0);
    chk("rst_slot_count", slot_count, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rom_sprite", rom_sprite, 0);
    chk("rst_rom_line", rom_line, 0);
    chk("rst_slot_x", slot_x, 0);
    chk("rst_slot_pattern", slot_pattern, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single sprite and row boundaries.
    write_attr(0, 6'd1, 10'd100, 10'd50);
    run_scan(10'd60, 1'b0);
    run_scan(10'd81, 1'b0);
    run_scan(10'd82, 1'b0);
    run_scan(10'd49, 1'b0);

    // Overflow: ten sprites on line 200; second run also pulses start mid-scan.
    clear_table();
    for (int i = 0; i < 10; i++) write_attr(i, 6'(i + 1), 10'(i * 20), 10'(200 - i * 3));
    run_scan(10'd200, 1'b0);
    run_scan(10'd200, 1'b1);

    // Wrap-around and a disabled entry covering the line.
    clear_table();
    write_attr(3, 6'd5, 10'd300, 10'd1020);
    write_attr(7, 6'd0, 10'd10, 10'd0);
    run_scan(10'd4, 1'b0);

    // Random tables clustered around a random line.
    for (int t = 0; t < 6; t++) begin
      base = 10'($urandom);
      for (int i = 0; i < NSPRITES; i++)
        write_attr(i, ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                   10'($urandom), base - 10'($urandom_range(0, 45)));
      run_scan(base, 1'b0);
    end

    // Reset while the first fetch is in flight.
    clear_table();
    write_attr(0, 6'd9, 10'd33, 10'd100);
    @(negedge clk);
    start = 1'b1; next_line = 10'd110;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("fetch_no_write", slot_we, 1'b0);
    @(negedge clk);
    chk("rr_busy", busy, 1'b0);
    chk("rr_slot_we", slot_we, 1'b0);
    chk("rr_done", done, 1'b0);
    chk("rr_slot_count", slot_count, 0);
    chk("rr_overflow", overflow, 1'b0);
    chk("rr_rom_sprite", rom_sprite, 0);
    chk("rr_rom_line", rom_line, 0);
    chk("rr_slot_x", slot_x, 0);
    chk("rr_slot_idx", slot_idx, 0);
    chk("rr_slot_pattern", slot_pattern, 0);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {slot_we, done, busy}, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Sequences the sprite pattern ROM (`sprites`: `n_sprite`/`line` in, registered 32×24-bit `pattern` out one cycle later) once per scanline. During horizontal blanking it scans a 16-entry sprite attribute table and finds the sprites that intersect the next scanline. For each hit it fetches the matching 32-pixel row from the ROM and writes it, with its x position, into a slot of the downstream line buffer. It sits between the CPU-written attribute registers and the line-buffer/compositor in the VGA pipeline.

## Interface
- `NSPRITES`, 16 — attribute table entries (power of two).
- `SLOTS`, 8 — line-buffer slots available per scanline.
- `clk` in 1 — pixel-domain clock.
- `reset` in 1 — synchronous, active-high.
- `attr_we` in 1 — attribute table write strobe.
- `attr_addr` in $clog2(NSPRITES) — entry written.
- `attr_data` in 26 — {id[5:0], x[9:0], y[9:0]}; id 0 = disabled.
- `start` in 1 — one-cycle pulse at hblank start.
- `next_line` in 10 — scanline to prepare, sampled on `start`.
- `rom_sprite` out 6 — drives ROM `n_sprite`.
- `rom_line` out 10 — drives ROM `line` (row within sprite, 0..31).
- `rom_pattern` in 32×24 — ROM `pattern`.
- `slot_we` out 1 — line-buffer write strobe.
- `slot_idx` out $clog2(SLOTS) — slot written.
- `slot_x` out 10 — sprite x for that slot.
- `slot_pattern` out 32×24 — row pixels, equal to `rom_pattern` while `slot_we`.
- `slot_count` out $clog2(SLOTS)+1 — slots filled this line.
- `busy` out 1 — scan in progress.
- `done` out 1 — one-cycle pulse at scan end.
- `overflow` out 1 — more hits than `SLOTS` on this line.

## Operation
- Attribute table: written whenever `attr_we` is high, including while busy. A write to entry i in the same cycle entry i is scanned is not seen by the scan, which uses the old value. Reset clears every entry to 0.
- FSM states: IDLE, SCAN, FETCH, WRITE, DONE.
- IDLE: on `start`, latch `next_line`, set i=0, clear `slot_count` and `overflow`, go to SCAN. `start` outside IDLE is ignored.
- SCAN (entry i): diff = `next_line` − y, as 10-bit unsigned modulo arithmetic. Hit = id≠0 and diff<32.
  - Hit with `slot_count`<SLOTS: register `rom_sprite`=id, `rom_line`=diff zero-extended, `slot_x`=x; go to FETCH.
  - Hit with slots full: set `overflow`, advance i.
  - Miss: advance i.
  - After i=NSPRITES−1 with no fetch issued: go to DONE.
- FETCH: ROM samples the address. Go to WRITE.
- WRITE: `slot_we`=1, `slot_idx`=`slot_count`, `slot_pattern`=`rom_pattern`. At the clock edge `slot_count` increments and i advances. Go to SCAN, or to DONE if i was the last entry.
- DONE: `done`=1 for one cycle, then go to IDLE. `slot_count` and `overflow` hold until the next `start`.
- Slot priority: lower table index gets the lower slot.
- `busy` = state≠IDLE.

## Timing
- Reset values: state IDLE; all outputs 0; `rom_sprite`/`rom_line` 0.
- Miss costs 1 cycle. Hit costs 3 cycles (SCAN, FETCH, WRITE). An overflow hit costs 1 cycle.
- Scan length, `start` edge to `done` edge: NSPRITES + 2·(fetched hits) + 1 cycles. Worst case at default parameters: 16+16+1 = 33 cycles, well inside hblank.
- ROM address is stable from the FETCH cycle through the WRITE cycle.
- `reset` mid-scan: returns to IDLE the next cycle. No `slot_we` or `done` is issued after reset is asserted.
- Wrap-around: y=1020, `next_line`=4 gives diff=8, which is a hit.

## Structure
- `sprite_pkg` contains:
  - `sprite_attr_t` = {id, x, y}.
  - `SPRITE_W`=32, `SPRITE_H`=32, `ID_W`=6, `COORD_W`=10.
  - The pixel typedef `logic [23:0]`.
  - The state enum.
- Sub-module `sprite_attr_table`: register file with synchronous write, combinational read by scan index, and clear on reset.
- The scheduler FSM, scan index and slot counter live in the top module.

## Test plan
- Single sprite: id=1, x=100, y=50; `start` with `next_line`=60 → one `slot_we`: slot 0, `slot_x`=100, `rom_line`=10. `done` at cycle 16+2+1=19 after `start`; `slot_count`=1.
- Boundaries: y=50, `next_line`=81 → hit with `rom_line`=31. `next_line`=82 and `next_line`=49 → no write; `done` after 17 cycles.
- Overflow: 10 enabled sprites all covering line 200 → 8 writes in index order to slots 0..7; `overflow`=1; `slot_count`=8.
- Wrap: y=1020, `next_line`=4 → hit with `rom_line`=8. An id=0 entry covering the line → no write.
- `reset` asserted during the FETCH state → no `slot_we`; next cycle `busy`=0 and all outputs are 0. A `start` pulsed while busy has no effect.
